// File: rtl/riscv_pkg.sv
// Shared RV32I encoding constants and micro-op/FSM types for the program-load encoder.
package riscv_pkg;

    localparam logic [6:0]  OP_IMM    = 7'd19;
    localparam logic [6:0]  OP_REG    = 7'd51;
    localparam logic [6:0]  OP_LUI    = 7'd55;
    localparam logic [6:0]  OP_BRANCH = 7'd99;

    localparam logic [2:0]  F3_ADD    = 3'b000;
    localparam logic [2:0]  F3_BNE    = 3'b001;

    localparam logic [31:0] NOP_WORD  = 32'h00000013;

    typedef enum logic [2:0] {
        ENC_ADDI = 3'd0,
        ENC_BNE  = 3'd1,
        ENC_ADD  = 3'd2,
        ENC_LUI  = 3'd3
    } enc_op_t;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCEPT = 2'd1,
        S_WRITE  = 2'd2,
        S_DONE   = 2'd3
    } enc_state_t;

endpackage

// File: rtl/instr_pack.sv
// Combinational micro-op -> RV32I word packer; reserved ops become a NOP flagged bad.
// Range checks on immediates are built only with INSTR_ENCODER_RANGE_CHECK_EN defined.
module instr_pack
    import riscv_pkg::*;
#(
    parameter int A_WIDTH = 8
) (
    input  logic [2:0]         op,
    input  logic [4:0]         rd,
    input  logic [4:0]         rs1,
    input  logic [4:0]         rs2,
    input  logic [31:0]        imm,
    input  logic [A_WIDTH-1:0] pc,
    output logic [31:0]        word,
    output logic               bad
);

    logic [31:0] off;
    logic        unused_off_bits;

    // Branch offset is relative to the address the branch itself is written at.
    assign off             = imm - 32'(pc);
    assign unused_off_bits = ^{off[31:13], off[0]};

    // Field packing per micro-op, with optional immediate range rejection.
    always_comb begin
        word = NOP_WORD;
        bad  = 1'b0;
        case (op)
            ENC_ADDI: begin
                word = {imm[11:0], rs1, F3_ADD, rd, OP_IMM};
`ifdef INSTR_ENCODER_RANGE_CHECK_EN
                if (($signed(imm) < -32'sd2048) || ($signed(imm) > 32'sd2047)) begin
                    word = NOP_WORD;
                    bad  = 1'b1;
                end else begin
                    bad  = 1'b0;
                end
`endif
            end
            ENC_BNE: begin
                word = {off[12], off[10:5], rs2, rs1, F3_BNE, off[4:1], off[11], OP_BRANCH};
`ifdef INSTR_ENCODER_RANGE_CHECK_EN
                if (($signed(off) < -32'sd4096) || ($signed(off) > 32'sd4094) || off[0]) begin
                    word = NOP_WORD;
                    bad  = 1'b1;
                end else begin
                    bad  = 1'b0;
                end
`endif
            end
            ENC_ADD: begin
                word = {7'b0000000, rs2, rs1, F3_ADD, rd, OP_REG};
            end
            ENC_LUI: begin
                word = {imm[19:0], rd, OP_LUI};
`ifdef INSTR_ENCODER_RANGE_CHECK_EN
                if (imm[31:20] != 12'h000) begin
                    word = NOP_WORD;
                    bad  = 1'b1;
                end else begin
                    bad  = 1'b0;
                end
`endif
            end
            default: begin
                word = NOP_WORD;
                bad  = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Program-load FSM: accepts micro-ops, encodes them and writes consecutive words to
// instruction memory. Optional immediate range checking: INSTR_ENCODER_RANGE_CHECK_EN.
module instr_encoder
    import riscv_pkg::*;
#(
    parameter int D_WIDTH   = 32,
    parameter int A_WIDTH   = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         in_op,
    input  logic [4:0]         in_rd,
    input  logic [4:0]         in_rs1,
    input  logic [4:0]         in_rs2,
    input  logic [31:0]        in_imm,
    input  logic               in_last,
    output logic               mem_we,
    output logic [A_WIDTH-1:0] mem_addr,
    output logic [D_WIDTH-1:0] mem_wdata,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [A_WIDTH-2:0] wr_count
);

    localparam logic [A_WIDTH-1:0] BASE     = A_WIDTH'(BASE_ADDR);
    localparam logic [A_WIDTH-1:0] TOP_ADDR = ~(A_WIDTH'(3));

    enc_state_t         state_r;
    enc_state_t         next_s;
    logic [A_WIDTH-1:0] pc_r;
    logic [D_WIDTH-1:0] word_r;
    logic               last_r;
    logic               bad_r;
    logic               err_r;
    logic               busy_r;
    logic [A_WIDTH-2:0] wr_count_r;
    logic [31:0]        pack_word_s;
    logic               pack_bad_s;
    logic               full_s;

    instr_pack #(.A_WIDTH(A_WIDTH)) u_pack (
        .op   (in_op),
        .rd   (in_rd),
        .rs1  (in_rs1),
        .rs2  (in_rs2),
        .imm  (in_imm),
        .pc   (pc_r),
        .word (pack_word_s),
        .bad  (pack_bad_s)
    );

    assign full_s = (pc_r == TOP_ADDR);

    // Next-state selection and state-decoded handshake/strobe outputs.
    always_comb begin
        next_s   = state_r;
        in_ready = 1'b0;
        mem_we   = 1'b0;
        done     = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (start) next_s = S_ACCEPT;
                else       next_s = S_IDLE;
            end
            S_ACCEPT: begin
                in_ready = 1'b1;
                if (in_valid) next_s = S_WRITE;
                else          next_s = S_ACCEPT;
            end
            S_WRITE: begin
                mem_we = 1'b1;
                if (last_r || bad_r || full_s) next_s = S_DONE;
                else                           next_s = S_ACCEPT;
            end
            S_DONE: begin
                done   = 1'b1;
                next_s = S_IDLE;
            end
            default: begin
                next_s = S_IDLE;
            end
        endcase
    end

    // State, write pointer, captured word and sticky status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= S_IDLE;
            pc_r       <= BASE;
            word_r     <= '0;
            last_r     <= 1'b0;
            bad_r      <= 1'b0;
            err_r      <= 1'b0;
            busy_r     <= 1'b0;
            wr_count_r <= '0;
        end else begin
            state_r <= next_s;
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        pc_r       <= BASE;
                        wr_count_r <= '0;
                        err_r      <= 1'b0;
                        busy_r     <= 1'b1;
                    end
                end
                S_ACCEPT: begin
                    if (in_valid) begin
                        word_r <= D_WIDTH'(pack_word_s);
                        last_r <= in_last;
                        bad_r  <= pack_bad_s;
                        err_r  <= err_r | pack_bad_s;
                    end
                end
                S_WRITE: begin
                    pc_r       <= pc_r + A_WIDTH'(4);
                    wr_count_r <= wr_count_r + (A_WIDTH-1)'(1);
                    // Filling the last word without an end-of-program marker is an overflow.
                    if (full_s && !last_r) err_r <= 1'b1;
                end
                S_DONE: begin
                    busy_r <= 1'b0;
                end
                default: begin
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign mem_addr  = pc_r;
    assign mem_wdata = word_r;
    assign busy      = busy_r;
    assign err       = err_r;
    assign wr_count  = wr_count_r;

endmodule

// File: tb/tb_instr_encoder.sv
// Randomized self-checking bench for instr_encoder against a transaction-level encoding model.
module tb_instr_encoder;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, in_valid, in_last;
    logic [2:0]  in_op;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [31:0] in_imm;
    logic        in_ready, mem_we, busy, done, err;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [6:0]  wr_count;

    logic        s_start, s_valid, s_ready, s_we, s_busy, s_done, s_err;
    logic [3:0]  s_addr;
    logic [31:0] s_wdata;
    logic [2:0]  s_count;

    instr_encoder #(.D_WIDTH(32), .A_WIDTH(8), .BASE_ADDR(0)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .in_last(in_last), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .err(err), .wr_count(wr_count)
    );

    instr_encoder #(.D_WIDTH(32), .A_WIDTH(4), .BASE_ADDR(0)) dut_small (
        .clk(clk), .rst(rst), .start(s_start), .in_valid(s_valid), .in_ready(s_ready),
        .in_op(3'd0), .in_rd(5'd1), .in_rs1(5'd0), .in_rs2(5'd0), .in_imm(32'd7),
        .in_last(1'b0), .mem_we(s_we), .mem_addr(s_addr), .mem_wdata(s_wdata),
        .busy(s_busy), .done(s_done), .err(s_err), .wr_count(s_count)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Spec-level encoder: returns {bad, word}.
    function automatic logic [32:0] model_enc(input int op, input int rd, input int rs1,
                                              input int rs2, input logic [31:0] imm,
                                              input logic [31:0] pc);
        logic [31:0] off, w;
        bit bad;
        off = imm - pc;
        bad = 1'b0;
        case (op)
            0: w = ((imm & 32'hFFF) << 20) | (rs1 << 15) | (rd << 7) | 32'd19;
            1: w = (((off >> 12) & 32'd1) << 31) | (((off >> 5) & 32'd63) << 25) | (rs2 << 20)
                   | (rs1 << 15) | (32'd1 << 12) | (((off >> 1) & 32'd15) << 8)
                   | (((off >> 11) & 32'd1) << 7) | 32'd99;
            2: w = (rs2 << 20) | (rs1 << 15) | (rd << 7) | 32'd51;
            3: w = ((imm & 32'hFFFFF) << 12) | (rd << 7) | 32'd55;
            default: begin w = 32'h13; bad = 1'b1; end
        endcase
`ifdef INSTR_ENCODER_RANGE_CHECK_EN
        if (op == 0 && ($signed(imm) < -2048 || $signed(imm) > 2047)) bad = 1'b1;
        if (op == 1 && ($signed(off) < -4096 || $signed(off) > 4094 || off[0])) bad = 1'b1;
        if (op == 3 && imm[31:20] != 12'h000) bad = 1'b1;
        if (bad) w = 32'h13;
`endif
        return {bad, w};
    endfunction

    typedef struct { logic [7:0] a; logic [31:0] d; } wr_t;
    wr_t         expq[$];
    wr_t         cur;
    logic        exp_err;
    int          exp_cnt;
    int          done_cnt = 0;

    int          p_op[16], p_rd[16], p_rs1[16], p_rs2[16];
    logic [31:0] p_imm[16];
    bit          p_last[16];

    // Per-cycle compare of memory writes and end-of-load status against the model.
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_we) begin
                check("ready_low_in_write", {31'd0, in_ready}, 32'd0);
                if (expq.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_write: addr %h data %h, none expected", mem_addr, mem_wdata);
                end else begin
                    cur = expq.pop_front();
                    check("wr_addr", {24'd0, mem_addr}, {24'd0, cur.a});
                    check("wr_data", mem_wdata, cur.d);
                end
            end
            if (done) begin
                check("done_err", {31'd0, err}, {31'd0, exp_err});
                check("done_count", {25'd0, wr_count}, 32'(exp_cnt));
                check("done_all_written", 32'(expq.size()), 32'd0);
                done_cnt++;
            end
        end
    end

    task automatic drive_random_op();
        in_op  = 3'($urandom);
        in_rd  = 5'($urandom);
        in_rs1 = 5'($urandom);
        in_rs2 = 5'($urandom);
        in_imm = $urandom;
        in_last = 1'($urandom);
    endtask

    task automatic run_prog(input int n, input int gap_max);
        logic [7:0]  pc_m;
        logic [32:0] r;
        bit          fin;
        int          base_done, budget;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        check("busy_after_start", {31'd0, busy}, 32'd1);
        pc_m = 8'd0; exp_err = 1'b0; exp_cnt = 0; fin = 1'b0; base_done = done_cnt;
        for (int i = 0; i < n && !fin; i++) begin
            repeat ($urandom_range(gap_max, 0)) begin
                in_valid = 1'b0; drive_random_op(); @(negedge clk);
            end
            in_valid = 1'b1;
            in_op = 3'(p_op[i]); in_rd = 5'(p_rd[i]); in_rs1 = 5'(p_rs1[i]);
            in_rs2 = 5'(p_rs2[i]); in_imm = p_imm[i]; in_last = p_last[i];
            budget = 0;
            while (!in_ready && budget < 10) begin @(negedge clk); budget++; end
            if (!in_ready) begin
                n_cmp++; n_bad++;
                $display("FAIL ready_timeout: in_ready 0 after 10 cycles, required 1");
                break;
            end
            r = model_enc(p_op[i], p_rd[i], p_rs1[i], p_rs2[i], p_imm[i], {24'd0, pc_m});
            expq.push_back('{pc_m, r[31:0]});
            exp_cnt++;
            if (r[32]) exp_err = 1'b1;
            if (p_last[i] || r[32]) fin = 1'b1;
            if (pc_m == 8'hFC && !p_last[i]) begin exp_err = 1'b1; fin = 1'b1; end
            pc_m = pc_m + 8'd4;
            @(negedge clk);
            check("write_latency", {31'd0, mem_we}, 32'd1);
        end
        budget = 0;
        while (done_cnt == base_done && budget < 20) begin
            in_valid = 1'($urandom); drive_random_op();
            @(negedge clk); budget++;
        end
        if (done_cnt == base_done) begin
            n_cmp++; n_bad++;
            $display("FAIL done_timeout: no done pulse within 20 cycles");
        end
        repeat (3) begin in_valid = 1'($urandom); drive_random_op(); @(negedge clk); end
        in_valid = 1'b0;
        check("busy_after_done", {31'd0, busy}, 32'd0);
        check("idle_not_ready", {31'd0, in_ready}, 32'd0);
        expq.delete();
    endtask

    task automatic set_op(input int i, input int op, input int rd, input int rs1,
                          input int rs2, input logic [31:0] imm, input bit last);
        p_op[i] = op; p_rd[i] = rd; p_rs1[i] = rs1; p_rs2[i] = rs2; p_imm[i] = imm; p_last[i] = last;
    endtask

    initial begin
        logic [32:0] pin;
        int nw;
        bit seen;
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        in_op = 3'd0; in_rd = 5'd0; in_rs1 = 5'd0; in_rs2 = 5'd0; in_imm = 32'd0;
        s_start = 1'b0; s_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_mem_addr", {24'd0, mem_addr}, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_busy_done_err", {29'd0, busy, done, err}, 32'd0);
        check("rst_wr_count", {25'd0, wr_count}, 32'd0);
        rst = 1'b0;

        // Hand-computed words that pin the model.
        pin = model_enc(0, 1, 0, 0, 32'd5, 32'd0);          check("pin_addi5", pin[31:0], 32'h00500093);
        pin = model_enc(0, 2, 0, 0, 32'hFFFFFFFF, 32'd4);   check("pin_addim1", pin[31:0], 32'hFFF00113);
        pin = model_enc(1, 0, 1, 2, 32'd0, 32'd8);          check("pin_bne", pin[31:0], 32'hFE209CE3);
        pin = model_enc(2, 3, 1, 2, 32'd0, 32'd0);          check("pin_add", pin[31:0], 32'h002081B3);
        pin = model_enc(3, 5, 0, 0, 32'h00012345, 32'd0);   check("pin_lui", pin[31:0], 32'h123452B7);
        pin = model_enc(6, 1, 1, 1, 32'd0, 32'd0);          check("pin_badop", pin, {1'b1, 32'h00000013});

        // Single ADDI; two ADDIs plus backward BNE with in_valid held high.
        set_op(0, 0, 1, 0, 0, 32'd5, 1'b1);
        run_prog(1, 0);
        set_op(0, 0, 1, 0, 0, 32'd5, 1'b0);
        set_op(1, 0, 2, 0, 0, 32'hFFFFFFFF, 1'b0);
        set_op(2, 1, 0, 1, 2, 32'd0, 1'b1);
        run_prog(3, 0);

        // Reserved op ends the load with a NOP and err.
        set_op(0, 2, 3, 1, 2, 32'd0, 1'b0);
        set_op(1, 6, 1, 1, 1, 32'd0, 1'b0);
        set_op(2, 0, 1, 0, 0, 32'd9, 1'b1);
        run_prog(3, 1);
`ifdef INSTR_ENCODER_RANGE_CHECK_EN
        set_op(0, 0, 1, 0, 0, 32'd4096, 1'b1);
        run_prog(1, 0);
`endif

        // Reset while a write is on the memory port.
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        in_valid = 1'b1; in_op = 3'd0; in_rd = 5'd4; in_rs1 = 5'd0; in_rs2 = 5'd0;
        in_imm = 32'd3; in_last = 1'b0;
        pin = model_enc(0, 4, 0, 0, 32'd3, 32'd0);
        expq.push_back('{8'd0, pin[31:0]});
        @(negedge clk);
        check("pre_rst_we", {31'd0, mem_we}, 32'd1);
        #1 rst = 1'b1;
        @(negedge clk);
        check("rst_mid_we", {31'd0, mem_we}, 32'd0);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_addr", {24'd0, mem_addr}, 32'd0);
        check("rst_mid_count_err", {24'd0, wr_count, err}, 32'd0);
        in_valid = 1'b0; rst = 1'b0;
        expq.delete();
        set_op(0, 3, 7, 0, 0, 32'h000ABCDE, 1'b1);
        run_prog(1, 0);

        // Random programs.
        for (int t = 0; t < 25; t++) begin
            int n;
            n = $urandom_range(8, 1);
            for (int i = 0; i < n; i++) begin
                int op;
                logic [31:0] imm;
                op = ($urandom_range(9, 0) == 0) ? $urandom_range(7, 4) : $urandom_range(3, 0);
                imm = ($urandom_range(1, 0) == 0) ? 32'($signed($urandom_range(4000, 0)) - 2000) : $urandom;
                if (op == 1 && $urandom_range(1, 0) == 0) imm = {24'd0, 6'($urandom), 2'b00};
                set_op(i, op, $urandom_range(31, 0), $urandom_range(31, 0), $urandom_range(31, 0),
                       imm, i == n - 1);
            end
            run_prog(n, 2);
        end

        // Small memory: four words fill it, continuous valid without last.
        @(negedge clk); s_start = 1'b1; s_valid = 1'b1;
        @(negedge clk); s_start = 1'b0;
        nw = 0; seen = 1'b0;
        for (int c = 0; c < 30; c++) begin
            if (s_we) begin
                pin = model_enc(0, 1, 0, 0, 32'd7, 32'(4 * nw));
                check("small_addr", {28'd0, s_addr}, 32'(4 * nw));
                check("small_data", s_wdata, pin[31:0]);
                check("small_ready_low", {31'd0, s_ready}, 32'd0);
                nw++;
            end
            if (s_done) begin
                check("small_err", {31'd0, s_err}, 32'd1);
                check("small_count", {29'd0, s_count}, 32'd4);
                seen = 1'b1;
            end
            @(negedge clk);
        end
        s_valid = 1'b0;
        check("small_writes", 32'(nw), 32'd4);
        check("small_done_seen", {31'd0, seen}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
